// File: rtl/rtc_field_editor_if.sv
// rtc_field_editor_if: RTC register bus between the field editor (master)
// and the RTC bus interface (slave). Carries the address, write data and
// read data plus the independent read and write req/ack handshakes.
interface rtc_field_editor_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] dir_rtc;
  logic [DATA_W-1:0] dato_out;
  logic              rd_req;
  logic              wr_req;
  logic [DATA_W-1:0] dato_rtc;
  logic              rd_ack;
  logic              wr_ack;

  modport master (
    output dir_rtc, dato_out, rd_req, wr_req,
    input  dato_rtc, rd_ack, wr_ack
  );

  modport slave (
    input  dir_rtc, dato_out, rd_req, wr_req,
    output dato_rtc, rd_ack, wr_ack
  );
endinterface

// File: rtl/rtc_field_editor.sv
// rtc_field_editor: reads a 3-field BCD register group (time, date or
// chronometer) from the RTC bus into a shadow buffer, lets the push buttons
// edit it, and writes it back when the mode request is released. Also
// clears the chronometer registers on reinicio.
// Optional hold-to-repeat on up/down: define RTC_FIELD_EDITOR_AUTOREPEAT_EN.
module rtc_field_editor #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] HORA_BASE  = 8'h21,
  parameter logic [ADDR_W-1:0] FECHA_BASE = 8'h24,
  parameter logic [ADDR_W-1:0] CRONO_BASE = 8'h41,
  parameter int                TIMEOUT    = 255,
  parameter int                REPEAT_DLY = 50000000,
  parameter int                REPEAT_PER = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  camb_crono,
  input  logic                  camb_hora,
  input  logic                  camb_fecha,
  input  logic                  reinicio,
  input  logic [3:0]            push,
  rtc_field_editor_if.master    bus,
  output logic [1:0]            campo_sel,
  output logic [3*DATA_W-1:0]   edit_data,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT, S_CLEAR} state_t;
  typedef enum logic [1:0] {M_HORA, M_FECHA, M_CRONO} mode_t;

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  if (TIMEOUT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
    $error("rtc_field_editor: TIMEOUT, REPEAT_DLY and REPEAT_PER must be at least 1");
  end

  state_t            state, nxt_state;
  mode_t             mode, nxt_mode;
  logic [ADDR_W-1:0] base, nxt_base;
  logic [1:0]        idx, nxt_idx;
  logic [2:0][7:0]   shadow, nxt_shadow;
  logic [1:0]        nxt_campo;
  logic              rd_req_q, nxt_rd_req;
  logic              wr_req_q, nxt_wr_req;
  logic [ADDR_W-1:0] dir_q, nxt_dir;
  logic [DATA_W-1:0] dato_q, nxt_dato;
  logic [TMO_W-1:0]  tmo_cnt, nxt_tmo;
  logic              nxt_err;
  logic [3:0]        push_q;
  logic [3:0]        rise;
  logic              mode_active;
  logic              rpt_up, rpt_down;

  function automatic logic [7:0] field_min(mode_t m, logic [1:0] i);
    return (m == M_FECHA && i != 2'd2) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] field_max(mode_t m, logic [1:0] i);
    if (m == M_FECHA) begin
      if (i == 2'd0) return 8'h31;
      if (i == 2'd1) return 8'h12;
      return 8'h99;
    end
    return (i == 2'd2) ? 8'h23 : 8'h59;
  endfunction

  // Garbage from the RTC (bad BCD nibble or out of range) loads as the minimum.
  function automatic logic [7:0] load_field(mode_t m, logic [1:0] i, logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v < field_min(m, i) || v > field_max(m, i))
      return field_min(m, i);
    return v;
  endfunction

  function automatic logic [7:0] bcd_up(mode_t m, logic [1:0] i, logic [7:0] v);
    if (v == field_max(m, i)) return field_min(m, i);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_down(mode_t m, logic [1:0] i, logic [7:0] v);
    if (v == field_min(m, i)) return field_max(m, i);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  assign rise      = push & ~push_q;
  assign busy      = (state != S_IDLE);
  assign edit_data = {DATA_W'(shadow[2]), DATA_W'(shadow[1]), DATA_W'(shadow[0])};

  assign bus.rd_req   = rd_req_q;
  assign bus.wr_req   = wr_req_q;
  assign bus.dir_rtc  = dir_q;
  assign bus.dato_out = dato_q;

  // The edit session lasts as long as the request that opened it stays high.
  always_comb begin
    case (mode)
      M_HORA:  mode_active = camb_hora;
      M_FECHA: mode_active = camb_fecha;
      default: mode_active = camb_crono;
    endcase
  end

`ifdef RTC_FIELD_EDITOR_AUTOREPEAT_EN
  logic [31:0] hold_cnt;
  logic        hold_rep;
  logic        held_up, held_down, hold_hit;

  assign held_up   = push[0] & push_q[0];
  assign held_down = push[1] & push_q[1] & ~push[0];
  assign hold_hit  = hold_rep ? (hold_cnt == 32'(REPEAT_PER - 1))
                              : (hold_cnt == 32'(REPEAT_DLY - 1));
  assign rpt_up    = (state == S_EDIT) && held_up && hold_hit;
  assign rpt_down  = (state == S_EDIT) && held_down && hold_hit;

  // Hold timer: first repeat after REPEAT_DLY, then every REPEAT_PER cycles.
  always_ff @(posedge clk) begin
    if (reset || state != S_EDIT || !(held_up || held_down) || nxt_campo != campo_sel) begin
      hold_cnt <= '0;
      hold_rep <= 1'b0;
    end else if (hold_hit) begin
      hold_cnt <= '0;
      hold_rep <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 32'd1;
    end
  end
`else
  assign rpt_up   = 1'b0;
  assign rpt_down = 1'b0;
`endif

  // Next-state logic: mode dispatch, read/write sequencing with ack timeout,
  // and the button-driven field edits.
  always_comb begin
    nxt_state  = state;
    nxt_mode   = mode;
    nxt_base   = base;
    nxt_idx    = idx;
    nxt_shadow = shadow;
    nxt_campo  = campo_sel;
    nxt_rd_req = rd_req_q;
    nxt_wr_req = wr_req_q;
    nxt_dir    = dir_q;
    nxt_dato   = dato_q;
    nxt_tmo    = tmo_cnt;
    nxt_err    = 1'b0;

    case (state)
      S_IDLE: begin
        if (reinicio) begin
          nxt_state  = S_CLEAR;
          nxt_base   = CRONO_BASE;
          nxt_idx    = 2'd0;
          nxt_wr_req = 1'b1;
          nxt_dir    = CRONO_BASE;
          nxt_dato   = '0;
          nxt_tmo    = '0;
        end else if (camb_crono || camb_hora || camb_fecha) begin
          if (camb_crono) begin
            nxt_mode = M_CRONO;
            nxt_base = CRONO_BASE;
          end else if (camb_hora) begin
            nxt_mode = M_HORA;
            nxt_base = HORA_BASE;
          end else begin
            nxt_mode = M_FECHA;
            nxt_base = FECHA_BASE;
          end
          nxt_state  = S_LOAD;
          nxt_idx    = 2'd0;
          nxt_rd_req = 1'b1;
          nxt_dir    = nxt_base;
          nxt_tmo    = '0;
        end
      end

      S_LOAD: begin
        if (rd_req_q) begin
          if (bus.rd_ack) begin
            nxt_rd_req      = 1'b0;
            nxt_shadow[idx] = load_field(mode, idx, bus.dato_rtc[7:0]);
            if (idx == 2'd2) begin
              nxt_state = S_EDIT;
              nxt_campo = 2'd0;
            end else begin
              nxt_idx = idx + 2'd1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            nxt_rd_req = 1'b0;
            nxt_err    = 1'b1;
            nxt_state  = S_IDLE;
          end else begin
            nxt_tmo = tmo_cnt + 1'b1;
          end
        end else begin
          nxt_rd_req = 1'b1;
          nxt_dir    = base + ADDR_W'(idx);
          nxt_tmo    = '0;
        end
      end

      S_EDIT: begin
        if (!mode_active) begin
          nxt_state  = S_COMMIT;
          nxt_idx    = 2'd0;
          nxt_wr_req = 1'b1;
          nxt_dir    = base;
          nxt_dato   = DATA_W'(shadow[0]);
          nxt_tmo    = '0;
        end else if (rise[0] || rpt_up) begin
          nxt_shadow[campo_sel] = bcd_up(mode, campo_sel, shadow[campo_sel]);
        end else if (rise[1] || rpt_down) begin
          nxt_shadow[campo_sel] = bcd_down(mode, campo_sel, shadow[campo_sel]);
        end else if (rise[3]) begin
          nxt_campo = (campo_sel == 2'd2) ? 2'd0 : campo_sel + 2'd1;
        end else if (rise[2]) begin
          nxt_campo = (campo_sel == 2'd0) ? 2'd2 : campo_sel - 2'd1;
        end
      end

      S_COMMIT, S_CLEAR: begin
        if (wr_req_q) begin
          if (bus.wr_ack) begin
            nxt_wr_req = 1'b0;
            if (idx == 2'd2) nxt_state = S_IDLE;
            else             nxt_idx   = idx + 2'd1;
          end else if (tmo_cnt == TMO_LAST) begin
            nxt_wr_req = 1'b0;
            nxt_err    = 1'b1;
            nxt_state  = S_IDLE;
          end else begin
            nxt_tmo = tmo_cnt + 1'b1;
          end
        end else begin
          nxt_wr_req = 1'b1;
          nxt_dir    = base + ADDR_W'(idx);
          nxt_dato   = (state == S_CLEAR) ? '0 : DATA_W'(shadow[idx]);
          nxt_tmo    = '0;
        end
      end

      default: nxt_state = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any pending request at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mode      <= M_HORA;
      base      <= '0;
      idx       <= '0;
      shadow    <= '0;
      campo_sel <= '0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      dir_q     <= '0;
      dato_q    <= '0;
      tmo_cnt   <= '0;
      err       <= 1'b0;
      push_q    <= '0;
    end else begin
      state     <= nxt_state;
      mode      <= nxt_mode;
      base      <= nxt_base;
      idx       <= nxt_idx;
      shadow    <= nxt_shadow;
      campo_sel <= nxt_campo;
      rd_req_q  <= nxt_rd_req;
      wr_req_q  <= nxt_wr_req;
      dir_q     <= nxt_dir;
      dato_q    <= nxt_dato;
      tmo_cnt   <= nxt_tmo;
      err       <= nxt_err;
      push_q    <= push;
    end
  end

endmodule
